// File: rtl/lc_pkg.sv
// Shared types and constants for the lower-cache port arbiter.
// Imported by lc_arbiter and lc_tag_fifo.
package lc_pkg;

    localparam int LC_ADDR_W = 64;
    localparam int LC_LINE_W = 512;
    localparam int LC_NUM_CH = 2;

    // Index width for n items, never below one bit.
    function automatic int lc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LC_CH_W = lc_idx_w(LC_NUM_CH);

    typedef logic [LC_CH_W-1:0] lc_ch_idx_t;

    typedef struct packed {
        logic [LC_ADDR_W-1:0] addr;
        logic [LC_LINE_W-1:0] value;
        logic                 we;
    } lc_req_t;

endpackage

// File: rtl/lc_tag_fifo.sv
// In-order tag FIFO holding the owner channel of each outstanding read.
// Circular buffer with wrap-around pointers and an occupancy count.
module lc_tag_fifo
    import lc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [TAG_W-1:0] o_head
);

    localparam int PW = lc_idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_tag;
        end
    end

    // Pointers and count; push and pop together leave the count alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/lc_arbiter.sv
// Merges NUM_CH requestors onto one lower-cache port, routes read responses back.
// Define LC_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module lc_arbiter
    import lc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = LC_ADDR_W,
    parameter int LINE_W = LC_LINE_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] req_valid_in,
    output logic [NUM_CH-1:0] req_ready_out,
    input  logic [ADDR_W-1:0] req_addr_in [NUM_CH],
    input  logic [LINE_W-1:0] req_value_in [NUM_CH],
    input  logic [NUM_CH-1:0] req_we_in,
    output logic [NUM_CH-1:0] resp_valid_out,
    input  logic [NUM_CH-1:0] resp_ready_in,
    output logic [ADDR_W-1:0] resp_addr_out,
    output logic [LINE_W-1:0] resp_value_out,
    output logic              lc_valid_out,
    input  logic              lc_ready_in,
    output logic [ADDR_W-1:0] lc_addr_out,
    output logic [LINE_W-1:0] lc_value_out,
    output logic              lc_we_out,
    input  logic              lc_valid_in,
    output logic              lc_ready_out,
    input  logic [ADDR_W-1:0] lc_addr_in,
    input  logic [LINE_W-1:0] lc_value_in
);

    localparam int CH_W = lc_idx_w(NUM_CH);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_value;
    logic              r_we;

    logic [NUM_CH-1:0] w_elig;
    logic [CH_W-1:0]   w_base;
    logic [CH_W-1:0]   w_gidx;
    logic              w_found;
    logic              w_go;
    logic              w_slot_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CH_W-1:0]   w_head;

`ifdef LC_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [CH_W-1:0] r_rr;

    assign w_base = r_rr;

    // Round-robin pointer moves just past the channel that won.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rr <= '0;
        end else if (w_go) begin
            r_rr <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
        end
    end
`endif

    assign w_elig     = req_valid_in & (req_we_in | {NUM_CH{!w_full}});
    assign w_slot_acc = !r_valid || lc_ready_in;
    assign w_go       = w_found && w_slot_acc && !rst_in;
    assign w_push     = w_go && !req_we_in[w_gidx];

    // First eligible channel at or after w_base, wrapping to the low end.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && w_elig[j] && (CH_W'(j) >= w_base)) begin
                w_found = 1'b1;
                w_gidx  = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && w_elig[j]) begin
                w_found = 1'b1;
                w_gidx  = CH_W'(j);
            end
        end
    end

    // One-hot request ready for the granted channel.
    always_comb begin
        req_ready_out = '0;
        if (w_go) req_ready_out[w_gidx] = 1'b1;
    end

    // Output slot: load on grant, drain on acceptance, hold while stalled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_value <= '0;
            r_we    <= 1'b0;
        end else if (w_go) begin
            r_valid <= 1'b1;
            r_addr  <= req_addr_in[w_gidx];
            r_value <= req_value_in[w_gidx];
            r_we    <= req_we_in[w_gidx];
        end else if (lc_ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign lc_valid_out = r_valid;
    assign lc_addr_out  = r_addr;
    assign lc_value_out = r_value;
    assign lc_we_out    = r_we;

    lc_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (CH_W)
    ) u_tags (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_push),
        .i_tag   (w_gidx),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign lc_ready_out   = !w_empty && resp_ready_in[w_head] && !rst_in;
    assign w_pop          = lc_valid_in && lc_ready_out;
    assign resp_addr_out  = lc_addr_in;
    assign resp_value_out = lc_value_in;

    // Route the response valid to the owner of the oldest outstanding read.
    always_comb begin
        resp_valid_out = '0;
        if (!w_empty && !rst_in) resp_valid_out[w_head] = lc_valid_in;
    end

    a_resp_has_tag: assert property (
        @(posedge clk_in) disable iff (rst_in) !(lc_valid_in && w_empty)
    );

endmodule

// File: tb/tb_lc_arbiter.sv
// Directed self-checking bench for lc_arbiter (NUM_CH=2, DEPTH=4).
// Expected values are hand-computed per step.
module tb_lc_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_ready;
    logic [ADDR_W-1:0] req_addr [NUM_CH];
    logic [LINE_W-1:0] req_value [NUM_CH];
    logic [NUM_CH-1:0] req_we;
    logic [NUM_CH-1:0] resp_valid;
    logic [NUM_CH-1:0] resp_ready;
    logic [ADDR_W-1:0] resp_addr;
    logic [LINE_W-1:0] resp_value;
    logic              lc_valid_o;
    logic              lc_ready_i;
    logic [ADDR_W-1:0] lc_addr_o;
    logic [LINE_W-1:0] lc_value_o;
    logic              lc_we_o;
    logic              lc_valid_i;
    logic              lc_ready_o;
    logic [ADDR_W-1:0] lc_addr_i;
    logic [LINE_W-1:0] lc_value_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [LINE_W-1:0] line_ab;
    logic [NUM_CH-1:0] exp_g [4];

    always #5 clk = ~clk;

    lc_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_addr_in    (req_addr),
        .req_value_in   (req_value),
        .req_we_in      (req_we),
        .resp_valid_out (resp_valid),
        .resp_ready_in  (resp_ready),
        .resp_addr_out  (resp_addr),
        .resp_value_out (resp_value),
        .lc_valid_out   (lc_valid_o),
        .lc_ready_in    (lc_ready_i),
        .lc_addr_out    (lc_addr_o),
        .lc_value_out   (lc_value_o),
        .lc_we_out      (lc_we_o),
        .lc_valid_in    (lc_valid_i),
        .lc_ready_out   (lc_ready_o),
        .lc_addr_in     (lc_addr_i),
        .lc_value_in    (lc_value_i)
    );

    task automatic chk(input string tag,
                       input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        line_ab     = {64{8'hAB}};
        exp_g[0]    = 2'b10;
        exp_g[1]    = 2'b01;
        exp_g[2]    = 2'b10;
        exp_g[3]    = 2'b01;
        rst         = 1'b1;
        req_valid   = 2'b01;
        req_we      = '0;
        req_addr[0] = 64'h2000;
        req_addr[1] = 64'h3000;
        req_value[0] = '0;
        req_value[1] = '0;
        resp_ready  = 2'b11;
        lc_ready_i  = 1'b1;
        lc_valid_i  = 1'b0;
        lc_addr_i   = '0;
        lc_value_i  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_lc_valid", lc_valid_o, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_lc_ready", lc_ready_o, 1'b0);
        rst       = 1'b0;
        req_valid = 2'b00;
        tick();

        // Single read from channel 0
        req_addr[0] = 64'h1000;
        req_valid   = 2'b01;
        #1;
        chk("t1_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_lc_valid", lc_valid_o, 1'b1);
        chk("t1_lc_addr", lc_addr_o, 64'h1000);
        chk("t1_lc_we", lc_we_o, 1'b0);
        tick();
        lc_valid_i = 1'b1;
        lc_addr_i  = 64'h1000;
        lc_value_i = line_ab;
        #1;
        chk("t1_slot_drained", lc_valid_o, 1'b0);
        chk("t1_resp_valid", resp_valid, 2'b01);
        chk("t1_resp_value", resp_value, line_ab);
        chk("t1_resp_addr", resp_addr, 64'h1000);
        chk("t1_lc_ready", lc_ready_o, 1'b1);
        tick();
        lc_valid_i = 1'b0;

        // Alternating reads; pointer starts at 1 after the channel-0 grant
        req_addr[0] = 64'h2000;
        req_valid   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_grant", req_ready, exp_g[i]);
            if (i > 0)
                chk("t2_lc_addr", lc_addr_o,
                    (exp_g[i-1] == 2'b01) ? 64'h2000 : 64'h3000);
            tick();
        end

        // Tag FIFO full: reads blocked
        #1;
        chk("t3_full_block", req_ready, 2'b00);
        chk("t3_lc_addr", lc_addr_o, 64'h2000);
        tick();

        // Write on channel 1 still goes through
        req_we       = 2'b10;
        req_addr[1]  = 64'h3800;
        req_value[1] = {16{32'hC0DE_0001}};
        #1;
        chk("t3_write_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        req_we    = 2'b00;
        #1;
        chk("t3_wr_lc_we", lc_we_o, 1'b1);
        chk("t3_wr_lc_value", lc_value_o, {16{32'hC0DE_0001}});

        // Pop while full does not release the read in the same cycle
        lc_valid_i = 1'b1;
        lc_value_i = {64{8'h11}};
        #1;
        chk("t3_pop_no_grant", req_ready, 2'b00);
        chk("t3_pop_resp", resp_valid, 2'b10);
        tick();
        lc_valid_i = 1'b0;
        #1;
        chk("t3_after_pop", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;

        // Response held off by resp_ready of head channel 0
        lc_valid_i = 1'b1;
        resp_ready = 2'b10;
        #1;
        chk("t4_resp_valid", resp_valid, 2'b01);
        chk("t4_lc_ready", lc_ready_o, 1'b0);
        tick();
        chk("t4_head_held", resp_valid, 2'b01);
        resp_ready = 2'b11;
        #1;
        chk("t4_lc_ready_up", lc_ready_o, 1'b1);
        tick();
        chk("t4_next_head", resp_valid, 2'b10);
        lc_valid_i = 1'b0;

        // Stall: slot full with lc_ready_in low
        lc_ready_i   = 1'b0;
        req_addr[0]  = 64'h4000;
        req_value[0] = {16{32'h5555_AAAA}};
        req_we       = 2'b01;
        req_addr[1]  = 64'h5000;
        req_valid    = 2'b11;
        #1;
        chk("t5_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_ready", req_ready, 2'b00);
            chk("t5_stall_valid", lc_valid_o, 1'b1);
            chk("t5_stall_addr", lc_addr_o, 64'h5000);
            chk("t5_stall_we", lc_we_o, 1'b0);
            tick();
        end
        lc_ready_i = 1'b1;
        #1;
        chk("t5_refill", req_ready, 2'b01);
        tick();
        req_valid  = 2'b00;
        req_we     = 2'b00;
        lc_ready_i = 1'b0;
        #1;
        chk("t5_lc_addr", lc_addr_o, 64'h4000);
        chk("t5_lc_we", lc_we_o, 1'b1);

        // Drain two of four tags, keep slot full, then reset
        lc_valid_i = 1'b1;
        tick();
        tick();
        lc_valid_i = 1'b0;
        rst        = 1'b1;
        req_valid  = 2'b11;
        tick();
        chk("t6_rst_lc_valid", lc_valid_o, 1'b0);
        chk("t6_rst_lc_addr", lc_addr_o, 64'h0);
        chk("t6_rst_lc_we", lc_we_o, 1'b0);
        chk("t6_rst_req_ready", req_ready, 2'b00);
        chk("t6_rst_resp_valid", resp_valid, 2'b00);
        chk("t6_rst_lc_ready", lc_ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_first_grant", req_ready, 2'b01);
        chk("t6_fifo_empty", lc_ready_o, 1'b0);
        tick();
        req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc_arbiter.md
# lc_arbiter

Parametrised lower-cache port arbiter that merges `NUM_CH` requestor channels onto the single `lc_*` lower-cache interface of the ozone core. Typical requestors are the frontend instruction fetch and the backend load/store path. Requests are arbitrated round-robin and registered onto the lower-cache port. The requesting channel of each read is recorded in an in-order tag FIFO so that read responses are routed back to their owner.

## Interface

Parameters:
- `NUM_CH`, default 2: number of requestor channels, ≥1.
- `ADDR_W`, default 64: address width.
- `LINE_W`, default 512: cache line width.
- `DEPTH`, default 4: maximum number of outstanding reads (tag FIFO depth), a power of two.

Ports (all per-channel ports are `[NUM_CH]` arrays):
- Clocking and reset: one clock, `clk_in`; reset is synchronous and active-high, `rst_in`.
- `clk_in`, in, 1: clock.
- `rst_in`, in, 1: synchronous active-high reset.
- `req_valid_in`, in, `[NUM_CH]`: channel request valid.
- `req_ready_out`, out, `[NUM_CH]`: channel request accepted this cycle.
- `req_addr_in`, in, `[NUM_CH][ADDR_W]`: request address.
- `req_value_in`, in, `[NUM_CH][LINE_W]`: write data.
- `req_we_in`, in, `[NUM_CH]`: 1 = write, 0 = read.
- `resp_valid_out`, out, `[NUM_CH]`: read response valid for the channel.
- `resp_ready_in`, in, `[NUM_CH]`: channel can take the response.
- `resp_addr_out`, out, `ADDR_W`: response address, shared by all channels.
- `resp_value_out`, out, `LINE_W`: response line, shared by all channels.
- `lc_valid_out`, out, 1: request to the lower cache.
- `lc_ready_in`, in, 1: lower cache accepts the request.
- `lc_addr_out`, out, `ADDR_W`: request address to the lower cache.
- `lc_value_out`, out, `LINE_W`: request write data to the lower cache.
- `lc_we_out`, out, 1: request write enable to the lower cache.
- `lc_valid_in`, in, 1: lower-cache read response valid.
- `lc_ready_out`, out, 1: arbiter accepts the response.
- `lc_addr_in`, in, `ADDR_W`: response address from the lower cache.
- `lc_value_in`, in, `LINE_W`: response line from the lower cache.

## Operation

Request path:
- A one-entry output register (`slot`) drives the `lc_*` request outputs. `lc_valid_out` is 1 exactly when the slot is full.
- The slot can accept a new request in a cycle when it is empty, or when it is full and `lc_ready_in` is 1 in that same cycle (pass-through refill).
- Eligible channels:
  - Any channel with `req_valid_in=1` and `req_we_in=1`.
  - Any channel with `req_valid_in=1` and `req_we_in=0`, provided the tag FIFO is not full.
- Grant goes to the first eligible channel at or after `rr_ptr`, with wrap-around. At most one `req_ready_out` bit is high in any cycle.
- On a request handshake:
  - The slot loads the channel's addr, value and we.
  - `rr_ptr` becomes (granted channel + 1) mod `NUM_CH`.
  - A read also pushes the channel index into the tag FIFO.
- While `lc_valid_out=1` and `lc_ready_in=0`, the slot contents are held stable.

Response path:
- Only reads produce responses; writes complete when the lower cache accepts them.
- Let `h` be the channel index at the head of the tag FIFO.
- `resp_valid_out[h] = lc_valid_in` when the FIFO is non-empty. All other bits are 0.
- `resp_addr_out` and `resp_value_out` pass `lc_addr_in` and `lc_value_in` through combinationally.
- `lc_ready_out = FIFO non-empty && resp_ready_in[h]`.
- On a response handshake the FIFO pops.
- If `lc_valid_in` arrives while the FIFO is empty, it is not accepted (`lc_ready_out=0`). This is a lower-cache protocol error and is flagged by an assertion.

Boundary cases:
- FIFO full: reads are not granted even if a pop occurs in the same cycle. This avoids a combinational path from `lc_valid_in` to `req_ready_out`. Writes from other channels still proceed.
- Simultaneous push and pop with the FIFO not full: the count is unchanged.
- Response ordering: the lower cache returns reads in issue order.
- A channel's request must stay stable (valid/ready rules) until it sees `req_ready_out`.

## Timing

- Request latency: handshake in cycle N puts `lc_valid_out=1` in cycle N+1. Back-to-back issue gives one request per cycle.
- Response latency: zero cycles (combinational routing).
- Behaviour in every cycle where `rst_in=1`, at the clock edge:
  - Slot cleared; `lc_valid_out`, `lc_addr_out`, `lc_value_out` and `lc_we_out` are 0.
  - `rr_ptr` = 0; FIFO emptied.
  - All `req_ready_out` = 0, all `resp_valid_out` = 0, `lc_ready_out` = 0.
- Reset mid-operation: the in-flight slot and outstanding tags are discarded. The lower cache must also be reset.

## Configuration

- `LC_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index eligible channel wins, and `rr_ptr` is not implemented.
- Macro not defined: round-robin as described under Operation.

## Structure

- Shared package `lc_pkg`:
  - `lc_req_t` struct {addr, value, we}.
  - `lc_ch_idx_t`, sized `$clog2(NUM_CH)`, minimum 1 bit.
  - Default `ADDR_W` and `LINE_W` constants.
- Sub-module `lc_tag_fifo`:
  - Parametrised by `DEPTH` and tag width.
  - Ports: push, pop, full, empty, head.
  - Implemented as a circular buffer with wrap-around pointers and a count.

## Test plan

- Single channel 0 read to addr 0x1000, `lc_ready_in=1` → `lc_valid_out=1` next cycle with addr 0x1000 and we=0. Response 0xAB.. on `lc_*_in` → `resp_valid_out=2'b01`, value 0xAB...
- Both channels issue reads continuously with `NUM_CH=2` → grants alternate 0,1,0,1. Responses return to channels 0,1,0,1 in order.
- `lc_ready_in=0` for 3 cycles while the slot is full → `lc_*` outputs stable, both `req_ready_out=0`. First acceptance occurs in the cycle `lc_ready_in` rises.
- `DEPTH=4`, 4 reads issued with no responses → 5th read has `req_ready_out=0`. A write on channel 1 is still granted. After one response, the read is granted next cycle.
- Response with `resp_ready_in[h]=0` → `lc_ready_out=0` and the FIFO head is unchanged until ready rises.
- `rst_in` asserted with a full slot and 2 outstanding tags → next cycle all outputs are 0, FIFO empty, and a new request is granted to channel 0 first.
